// File: rtl/la_iorseq.sv
// IO-ring power sequencer: qualifies supplies and en, then sequences ring switch
// enable and pad hold up (enable, settle, release hold) and down (hold, settle, disable).
module la_iorseq #(
    parameter int SYNC     = 2,
    parameter int DEBOUNCE = 4,
    parameter int SETTLE   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       vdd_ok,
    input  logic       vddio_ok,
    output logic       ring_en,
    output logic       hold,
    output logic       ready,
    output logic       fault,
    output logic [1:0] state
);

    localparam int CMAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [SYNC-1:0] vdd_sync_q, vdd_sync_d;
    logic [SYNC-1:0] vddio_sync_q, vddio_sync_d;
    logic [2:0]      st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            ring_en_q, ring_en_d;
    logic            hold_q, hold_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic [1:0]      state_q, state_d;
    logic            vdd_s, vddio_s, ok, qual;

    assign vdd_sync_d   = {vdd_sync_q[SYNC-2:0], vdd_ok};
    assign vddio_sync_d = {vddio_sync_q[SYNC-2:0], vddio_ok};
    assign vdd_s        = vdd_sync_q[SYNC-1];
    assign vddio_s      = vddio_sync_q[SYNC-1];
    assign ok           = vdd_s & vddio_s;
    assign qual         = en & ok;
    assign cnt_inc      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_inc;
        case (st_q)
            S_OFF: begin
                if (!qual)                  cnt_d = '0;
                else if (cnt_q == DEB_LAST) st_d  = S_RAMP;
            end
            S_RAMP: begin
                if (!ok)                    st_d = S_FAULT;
                else if (!en)               st_d = S_DOWN;
                else if (cnt_q == SET_LAST) st_d = S_ON;
            end
            S_ON: begin
                if (!ok)      st_d = S_FAULT;
                else if (!en) st_d = S_DOWN;
            end
            // en is deliberately ignored here: a started power-down always completes.
            S_DOWN: begin
                if (!ok)                    st_d = S_FAULT;
                else if (cnt_q == SET_LAST) st_d = S_OFF;
            end
            S_FAULT: begin
                if (!en) st_d = S_OFF;
            end
            default: st_d = S_OFF;
        endcase
        if (st_d != st_q) cnt_d = '0;

        // Outputs are decoded from the next state so they move on the same edge.
        ring_en_d = (st_d == S_RAMP) || (st_d == S_ON) || (st_d == S_DOWN);
        hold_d    = (st_d != S_ON);
        ready_d   = (st_d == S_ON);
        fault_d   = (st_d == S_FAULT);
        state_d   = (st_d == S_FAULT) ? 2'd3 : st_d[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdd_sync_q   <= '0;
            vddio_sync_q <= '0;
            st_q         <= S_OFF;
            cnt_q        <= '0;
            ring_en_q    <= 1'b0;
            hold_q       <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            state_q      <= 2'd0;
        end else begin
            vdd_sync_q   <= vdd_sync_d;
            vddio_sync_q <= vddio_sync_d;
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            ring_en_q    <= ring_en_d;
            hold_q       <= hold_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            state_q      <= state_d;
        end
    end

    assign ring_en = ring_en_q;
    assign hold    = hold_q;
    assign ready   = ready_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule

// File: tb/tb_la_iorseq.sv
// Bench for la_iorseq: directed power-up/down, glitch, fault and async-reset scenarios,
// checked every cycle against a phase/elapsed-time model plus literal timing pins.
module tb_la_iorseq;

    localparam int SYNC     = 2;
    localparam int DEBOUNCE = 4;
    localparam int SETTLE   = 16;

    localparam int M_OFF   = 0;
    localparam int M_RAMP  = 1;
    localparam int M_ON    = 2;
    localparam int M_DOWN  = 3;
    localparam int M_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       vdd_ok = 1'b0;
    logic       vddio_ok = 1'b0;
    logic       ring_en, hold, ready, fault;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    la_iorseq #(.SYNC(SYNC), .DEBOUNCE(DEBOUNCE), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .en(en), .vdd_ok(vdd_ok), .vddio_ok(vddio_ok),
        .ring_en(ring_en), .hold(hold), .ready(ready), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase, qualified-streak length, and edges elapsed in the current phase.
    int              m_ph = M_OFF;
    int              m_streak = 0;
    int              m_el = 0;
    logic [SYNC-1:0] m_vdd_h = '0;
    logic [SYNC-1:0] m_vddio_h = '0;

    task automatic model_next(input int ph, input int st, input int el, input logic okv,
                              input logic env, output int nph, output int nst, output int nel);
        nph = ph; nst = st; nel = el;
        case (ph)
            M_OFF: begin
                nst = (env && okv) ? st + 1 : 0;
                if (nst == DEBOUNCE) begin nph = M_RAMP; nel = 0; end
            end
            M_RAMP: begin
                nel = el + 1;
                if (!okv) nph = M_FAULT;
                else if (!env) begin nph = M_DOWN; nel = 0; end
                else if (nel == SETTLE) nph = M_ON;
            end
            M_ON: begin
                if (!okv) nph = M_FAULT;
                else if (!env) begin nph = M_DOWN; nel = 0; end
            end
            M_DOWN: begin
                nel = el + 1;
                if (!okv) nph = M_FAULT;
                else if (nel == SETTLE) begin nph = M_OFF; nst = 0; end
            end
            default: begin
                if (!env) begin nph = M_OFF; nst = 0; end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        int nph, nst, nel;
        if (rst) begin
            m_ph <= M_OFF; m_streak <= 0; m_el <= 0;
            m_vdd_h <= '0; m_vddio_h <= '0;
        end else begin
            model_next(m_ph, m_streak, m_el, m_vdd_h[SYNC-1] & m_vddio_h[SYNC-1], en,
                       nph, nst, nel);
            m_ph <= nph; m_streak <= nst; m_el <= nel;
            m_vdd_h   <= {m_vdd_h[SYNC-2:0], vdd_ok};
            m_vddio_h <= {m_vddio_h[SYNC-2:0], vddio_ok};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_ring_en", int'(ring_en),
                int'(m_ph == M_RAMP || m_ph == M_ON || m_ph == M_DOWN));
            chk("cyc_hold",  int'(hold),  int'(m_ph != M_ON));
            chk("cyc_ready", int'(ready), int'(m_ph == M_ON));
            chk("cyc_fault", int'(fault), int'(m_ph == M_FAULT));
            chk("cyc_state", int'(state), (m_ph == M_FAULT) ? 3 : m_ph);
            chk("cyc_unheld_off", int'(!ring_en && !hold), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int re, input int ho, input int rd,
                           input int fa, input int st);
        chk({name, "_ring_en"}, int'(ring_en), re);
        chk({name, "_hold"},    int'(hold),    ho);
        chk({name, "_ready"},   int'(ready),   rd);
        chk({name, "_fault"},   int'(fault),   fa);
        chk({name, "_state"},   int'(state),   st);
    endtask

    // Supplies up and settled, then en high: RAMP on the 4th edge, ON 16 edges later.
    task automatic power_up(input string name);
        vdd_ok = 1'b1; vddio_ok = 1'b1; en = 1'b0;
        step(4);
        en = 1'b1;
        step(3);  chk_out({name, "_deb3"}, 0, 1, 0, 0, 0);
        step(1);  chk_out({name, "_ramp"}, 1, 1, 0, 0, 1);
        step(15); chk_out({name, "_ramp15"}, 1, 1, 0, 0, 1);
        step(1);  chk_out({name, "_on"}, 1, 0, 1, 0, 2);
    endtask

    initial begin
        #12;
        chk_out("reset", 0, 1, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step(1);

        power_up("pu1");

        en = 1'b0;
        step(1);  chk_out("pd_t", 1, 1, 0, 0, 3);
        step(15); chk_out("pd_t15", 1, 1, 0, 0, 3);
        step(1);  chk_out("pd_off", 0, 1, 0, 0, 0);

        // Raw vddio low captured on E1 reaches the FSM on E3, breaking the streak.
        en = 1'b1;
        step(1); vddio_ok = 1'b0;
        step(1); vddio_ok = 1'b1;
        step(5); chk("glitch_still_off", int'(state), 0);
        step(1); chk("glitch_ramp", int'(state), 1);
        step(2); en = 1'b0;
        step(1);  chk_out("ramp_down", 1, 1, 0, 0, 3);
        step(16); chk_out("ramp_down_off", 0, 1, 0, 0, 0);

        power_up("pu2");
        vdd_ok = 1'b0;
        step(2); chk("fault_lat2", int'(state), 2);
        step(1); chk_out("fault_on", 0, 1, 0, 1, 3);
        step(3); chk_out("fault_hold", 0, 1, 0, 1, 3);
        en = 1'b0;
        step(1); chk_out("fault_clr", 0, 1, 0, 0, 0);
        vdd_ok = 1'b1;

        // en and synchronized ok drop on the same edge in RAMP: fault wins.
        step(3); en = 1'b1;
        step(4); chk("sim_ramp", int'(state), 1);
        step(2); vdd_ok = 1'b0;
        step(2); en = 1'b0;
        step(1); chk_out("sim_fault", 0, 1, 0, 1, 3);
        step(1); chk_out("sim_off", 0, 1, 0, 0, 0);
        vdd_ok = 1'b1;

        // Async reset between edges mid-RAMP.
        step(3); en = 1'b1;
        step(6); chk("rst_ramp_pre", int'(state), 1);
        #2 rst = 1'b1;
        #1 chk_out("rst_ramp", 0, 1, 0, 0, 0);
        #3 rst = 1'b0;
        power_up("pu3");

        // Async reset between edges mid-DOWN.
        en = 1'b0;
        step(5); chk("rst_down_pre", int'(state), 3);
        #2 rst = 1'b1;
        #1 chk_out("rst_down", 0, 1, 0, 0, 0);
        #3 rst = 1'b0;
        power_up("pu4");
        en = 1'b0;
        step(17); chk_out("final_off", 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/la_iorseq.md
# la_iorseq

IO-ring power sequencer, the controlling counterpart to the passive supply and ground pad cells. It watches the core-supply-good and IO-supply-good indications and, on request, brings the pad ring up in a fixed order. On the way up it enables the ring switch, lets the ring settle, and then releases pad hold. On the way down, or on a supply fault, it runs the reverse order so pads are never driven unheld with the ring switched off. It sits in the chip top, beside the IO ring, and drives the ring's switch and hold controls.

## Interface
Parameters:
- SYNC, 2: synchronizer depth for `vdd_ok` and `vddio_ok`; legal range ≥2.
- DEBOUNCE, 4: number of consecutive qualified cycles required before power-up; legal range ≥1.
- SETTLE, 16: number of cycles between the ring-enable change and the hold change; legal range ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  ring power-up request, synchronous to `clk`.
- `vdd_ok`  in  1  core supply good; asynchronous.
- `vddio_ok`  in  1  IO supply good; asynchronous.
- `ring_en`  out  1  IO-ring switch enable.
- `hold`  out  1  pad hold/isolate, active-high.
- `ready`  out  1  ring fully up.
- `fault`  out  1  supply dropped while the ring was enabled.
- `state`  out  2  current FSM state: OFF=0, RAMP=1, ON=2, DOWN/FAULT=3. Use `fault` to tell DOWN and FAULT apart.

## Operation
Input conditioning:
- `vdd_ok` and `vddio_ok` each pass through a SYNC-stage flop chain, producing `vdd_s` and `vddio_s`.
- `ok = vdd_s & vddio_s`.
- `qual = en & ok`.

Counter:
- One shared counter, width `$clog2(max(SETTLE,DEBOUNCE)+1)`.
- It is cleared on every state change. It never wraps: it saturates at its terminal value.

FSM states, outputs, and transitions:
- OFF (`ring_en`=0, `hold`=1, `ready`=0, `fault`=0):
  - The counter increments on each cycle where `qual`=1 and clears on any cycle where `qual`=0.
  - On the DEBOUNCE-th consecutive edge with `qual`=1, go to RAMP.
- RAMP (`ring_en`=1, `hold`=1):
  - If `ok`=0, go to FAULT. This has priority over every other transition.
  - Else if `en`=0, go to DOWN.
  - Else, once the counter has counted SETTLE edges, go to ON.
- ON (`ring_en`=1, `hold`=0, `ready`=1):
  - If `ok`=0, go to FAULT.
  - Else if `en`=0, go to DOWN.
- DOWN (`ring_en`=1, `hold`=1):
  - After SETTLE edges, go to OFF.
  - If `ok`=0 at any point, go to FAULT immediately.
  - `en` rising during DOWN is ignored; DOWN always completes through OFF.
- FAULT (`ring_en`=0, `hold`=1, `fault`=1):
  - Stays here while `en`=1.
  - On the first edge with `en`=0, go to OFF. `fault` clears there.

Output rules:
- All outputs are registered and change on the same edge as the state register.
- There is no cycle where `ring_en`=0 and `hold`=0 together.
- `hold` always rises on or before the edge where `ring_en` falls.

Reset:
- Reset forces OFF, clears the counter, and clears the synchronizers to 0.
- Reset values: `ring_en`=0, `hold`=1, `ready`=0, `fault`=0, `state`=0.
- Asserting reset mid-sequence (RAMP, ON, or DOWN) drops to the reset values asynchronously. No DOWN sequence runs.

## Timing
- Latency from a `vdd_ok`/`vddio_ok` edge to `ok`: SYNC clock edges.
- Power-up with `ok` already stable and `en` sampled high from edge 0:
  - `ring_en` rises after edge DEBOUNCE-1.
  - `hold` falls and `ready` rises SETTLE edges later.
- Power-down: `en` sampled low at edge t.
  - At t: `hold`=1 and `ready`=0.
  - `ring_en` falls at edge t+SETTLE.
- Fault: an `ok` input drops asynchronously.
  - `ring_en` falls, `hold` rises, and `fault` rises SYNC+1 edges later at most.
- Simultaneous events:
  - `ok`=0 together with `en`=0 in RAMP or ON: FAULT wins.
  - `qual` dropping on the DEBOUNCE-th edge: no transition, and the counter clears.

## Test plan
- Power-up (SYNC=2, DEBOUNCE=4, SETTLE=16): supplies high, then `en` held high → `ring_en`=1 after the 4th qualified edge; `hold`=0 and `ready`=1 exactly 16 edges later; `state` goes 0→1→2.
- Debounce glitch: `en` high with `vddio_ok` pulsed low for 1 cycle after 3 qualified edges → still OFF; RAMP only after 4 fresh consecutive qualified edges.
- Power-down: from ON, drop `en` → same edge `hold`=1 and `ready`=0, `state`=3, `fault`=0; `ring_en`=0 and `state`=0 after 16 edges.
- Fault in ON: drop `vdd_ok` → within 3 edges `ring_en`=0, `hold`=1, `fault`=1; `fault` stays set until `en`=0, then OFF on the next edge.
- Simultaneous `en`↓ and `ok`↓ in RAMP → FAULT, not DOWN; `ring_en`=0 immediately.
- Async reset asserted mid-RAMP and mid-DOWN, between clock edges → outputs go to 0/1/0/0 (`ring_en`/`hold`/`ready`/`fault`) without waiting for a clock edge; after release, a full power-up repeats with the same timing as the first scenario.
